// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - ARMv4 instruction fetch stage with prefetch queue and redirect flush
module fetch_unit #(
    parameter int             BUS      = 32,
    parameter int             DEPTH    = 4,
    parameter logic [BUS-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    output logic [BUS-1:0] imem_addr,
    input  logic [BUS-1:0] imem_data,
    output logic [BUS-1:0] instr,
    output logic [BUS-1:0] instr_pc,
    output logic [BUS-1:0] instr_pc8,
    output logic           instr_valid,
    input  logic           decode_ready,
    input  logic           redirect_valid,
    input  logic [BUS-1:0] redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_t;

    state_t         r_state, w_state_nxt;
    logic [BUS-1:0] r_pc, w_pc_nxt;
    logic [BUS-1:0] r_if_addr;
    logic           r_inflight, r_discard;
    logic [CW-1:0]  r_count, w_count_nxt;
    logic [PW-1:0]  r_head, r_tail;
    logic [BUS-1:0] r_q_data [DEPTH];
    logic [BUS-1:0] r_q_pc   [DEPTH];

    logic           w_issue, w_push, w_pop;
    logic [CW-1:0]  w_occupancy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Occupancy counts the in-flight read so a returning word always has a free slot.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_count_nxt = r_count;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_occupancy = r_count + CW'(r_inflight);
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = redirect_valid ? ST_FLUSH : ST_RUN;
            ST_FLUSH: w_state_nxt = redirect_valid ? ST_FLUSH : ST_RUN;
            default:  w_state_nxt = ST_BOOT;
        endcase
        if (redirect_valid) begin
            w_pc_nxt    = redirect_pc & ~BUS'(3);
            w_count_nxt = '0;
        end else begin
            w_issue = (r_state == ST_RUN) && (w_occupancy < CW'(DEPTH));
            w_push  = r_inflight && !r_discard;
            w_pop   = instr_valid && decode_ready;
            if (w_issue) begin
                w_pc_nxt = r_pc + BUS'(4);
            end
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= RESET_PC & ~BUS'(3);
            r_if_addr  <= '0;
            r_inflight <= 1'b0;
            r_discard  <= 1'b0;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else begin
            r_pc       <= w_pc_nxt;
            r_count    <= w_count_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_if_addr <= r_pc;
            end
            if (redirect_valid) begin
                r_discard <= r_inflight;
                r_head    <= '0;
                r_tail    <= '0;
            end else begin
                r_discard <= 1'b0;
                if (w_push) begin
                    r_q_data[r_tail] <= imem_data;
                    r_q_pc[r_tail]   <= r_if_addr;
                    r_tail           <= r_tail + PW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PW'(1);
                end
            end
        end
    end

    assign imem_addr   = r_pc;
    assign instr       = r_q_data[r_head];
    assign instr_pc    = r_q_pc[r_head];
    assign instr_pc8   = instr_pc + BUS'(8);
    assign instr_valid = (r_count != '0);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against a PC-stream reference model
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic [31:0] instr, instr_pc, instr_pc8;
    logic        instr_valid;
    logic        decode_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_accept = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_unit #(.BUS(32), .DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_pc8(instr_pc8),
        .instr_valid(instr_valid), .decode_ready(decode_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // Instruction memory: address latched at posedge, word registered on the following negedge.
    logic [31:0] addr_q = '0;
    always @(posedge clk) addr_q <= imem_addr;
    always @(negedge clk) imem_data <= memfn(addr_q);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // A new architectural stream: every later accepted instruction must be pc, pc+4, ...
    function automatic void start_stream(input logic [31:0] pc);
        logic [31:0] a;
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            a = pc + 32'(4 * i);
            exp_q.push_back('{pc: a, data: memfn(a)});
        end
    endfunction

    always @(negedge clk) begin
        if (reset && !redirect_valid && instr_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL stream_underrun: got pc %h, expected no instruction", instr_pc);
            end else begin
                chk("instr_pc", instr_pc, exp_q[0].pc);
                chk("instr", instr, exp_q[0].data);
                chk("instr_pc8", instr_pc8, exp_q[0].pc + 32'd8);
                if (decode_ready) begin
                    void'(exp_q.pop_front());
                    n_accept++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!instr_valid && n < 12);
        chk(name, n, exp_lat);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        start_stream(target & ~32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nv;
        int          r;
        logic [31:0] a0;
        reset = 1'b0; decode_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        start_stream(RESET_PC);
        repeat (3) tick();
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_pc8", instr_pc8, 8);
        chk("rst_addr", imem_addr, RESET_PC);

        reset = 1'b1;
        wait_valid("boot_latency", 3);
        chk("first_pc", instr_pc, RESET_PC);
        chk("first_pc8", instr_pc8, RESET_PC + 32'd8);
        nv = 0;
        repeat (20) begin
            tick();
            if (instr_valid) nv++;
        end
        chk("throughput", nv, 20);

        decode_ready = 1'b0;
        repeat (6) tick();
        a0 = imem_addr;
        repeat (4) tick();
        chk("stall_issue_stops", imem_addr, a0);
        chk("stall_valid", instr_valid, 1);
        decode_ready = 1'b1;
        repeat (20) tick();

        decode_ready = 1'b0;
        repeat (2) tick();
        redirect_to(32'h0000_0103);
        tick();
        redirect_valid = 1'b0;
        decode_ready   = 1'b1;
        chk("redir_drop", instr_valid, 0);
        wait_valid("redir_latency", 3);
        chk("redir_pc", instr_pc, 32'h0000_0100);
        repeat (10) tick();

        redirect_to(32'h0000_0200);
        tick();
        chk("redir2_drop", instr_valid, 0);
        redirect_to(32'h0000_0040);
        tick();
        redirect_valid = 1'b0;
        wait_valid("redir2_latency", 3);
        chk("redir2_pc", instr_pc, 32'h0000_0040);
        repeat (10) tick();

        redirect_to(32'hFFFF_FFF8);
        tick();
        redirect_valid = 1'b0;
        wait_valid("wrap_latency", 3);
        chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        chk("wrap_pc8", instr_pc8, 32'h0000_0000);
        tick();
        chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", instr_pc, 32'h0000_0000);
        repeat (5) tick();

        decode_ready = 1'b0;
        repeat (8) tick();
        reset = 1'b0;
        start_stream(RESET_PC);
        tick();
        chk("rerst_valid", instr_valid, 0);
        chk("rerst_addr", imem_addr, RESET_PC);
        reset = 1'b1;
        decode_ready = 1'b1;
        wait_valid("rerst_latency", 3);
        chk("rerst_pc", instr_pc, RESET_PC);

        for (int i = 0; i < 600; i++) begin
            decode_ready   = ($urandom_range(0, 3) != 0);
            redirect_valid = 1'b0;
            reset          = 1'b1;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                redirect_to($urandom());
            end else if (r == 4) begin
                reset = 1'b0;
                start_stream(RESET_PC);
            end
            tick();
        end
        reset = 1'b1; redirect_valid = 1'b0; decode_ready = 1'b1;
        repeat (10) tick();
        chk("progress", n_accept > 150, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the ARMv4 core; sits directly upstream of the instruction memory.
- Owns the PC and drives the word-aligned byte address to the memory read port.
- Captures returned instruction words into a small prefetch queue and presents them to decode with a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding any in-flight read.

Parameters:
- BUS, 32, data/address width.
- DEPTH, 4, prefetch queue entries (power of two, >= 2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-low.
- imem_addr  output  BUS  byte address to instruction memory; bits [1:0] always 0.
- imem_data  input  BUS  read data; holds the word for the imem_addr driven in the previous cycle.
- instr  output  BUS  head-of-queue instruction.
- instr_pc  output  BUS  address of instr.
- instr_pc8  output  BUS  instr_pc + 8, the architectural PC read value.
- instr_valid  output  1  queue non-empty.
- decode_ready  input  1  decode accepts instr this cycle.
- redirect_valid  input  1  branch/exception redirect request.
- redirect_pc  input  BUS  redirect target; bits [1:0] ignored.

Behaviour:
- Memory timing: memory samples imem_addr and registers on negedge. The word is sampled here at the next posedge, so fetch latency is 1 cycle.
- Reset (reset==0 at posedge):
  - pc <= RESET_PC; imem_addr = RESET_PC.
  - Queue count <= 0; inflight <= 0; discard <= 0; state <= BOOT.
  - instr_valid = 0; instr = 0; instr_pc = 0; instr_pc8 = 8.
  - Reset overrides redirect and handshake. Reset mid-stream drops all queued and in-flight words.
- FSM:
  - BOOT: one cycle, no issue, no capture (memory output is stale after reset). BOOT -> RUN unconditionally.
  - RUN: normal operation.
  - FLUSH: entered on redirect; lasts one cycle. FLUSH -> RUN.
  - redirect_valid in RUN -> FLUSH. redirect_valid in FLUSH stays FLUSH and reloads pc. redirect_valid in BOOT reloads pc, then -> RUN.
- Issue rule (RUN only, no redirect this cycle): issue when count + inflight < DEPTH.
  - On issue: imem_addr = pc; next cycle pc <= pc + 4 (wraps modulo 2^BUS, 32'hFFFF_FFFC -> 0); inflight <= 1.
  - No issue: inflight <= 0; imem_addr holds pc, and the result is ignored.
- Capture: if inflight==1 and discard==0, push {imem_data, addr_of_inflight} at the tail.
- Pop: instr_valid && decode_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Push never overflows: the issue rule reserves a slot. Pop on empty is ignored.
- Redirect (redirect_valid==1 in RUN or FLUSH):
  - Same cycle: count <= 0; pc <= {redirect_pc[BUS-1:2], 2'b00}; no issue; discard <= inflight.
  - Any pop in that cycle is also dropped.
  - instr_valid goes 0 on the next cycle.
  - FLUSH cycle: capture suppressed by discard; discard <= 0. First issue from the new pc occurs in the cycle after FLUSH.
  - Redirect-to-first-instr_valid latency: 3 cycles.
- Queue: circular buffer with head/tail pointers of width log2(DEPTH). Pointers wrap at DEPTH.
- instr/instr_pc come directly from the head entry (registered storage, no combinational path from imem_data). instr_pc8 = instr_pc + 8, modulo 2^BUS.
- Steady-state throughput: 1 instruction/cycle when decode_ready is held 1.

Test Plan:
- Reset release, RESET_PC=0, decode_ready=1 -> addresses 0,4,8,… issued from the 2nd cycle. First instr_valid 2 cycles after BOOT, with instr_pc=0 and instr_pc8=8. Then 1 instr/cycle, with instr matching program words.
- decode_ready=0 for 10 cycles -> count saturates at 4 (DEPTH) and issue stops. On release, 4 pops then streaming resumes; no word lost or duplicated, instr_pc strictly +4.
- redirect_valid with redirect_pc=32'h0000_0103 while inflight=1 and queue=3 -> instr_valid=0 next cycle, in-flight word dropped. Next instr_pc=32'h0000_0100, 3 cycles after redirect.
- redirect in same cycle as pop, then second redirect during FLUSH to 32'h40 -> only the 32'h40 stream appears; no word from the old or first-target stream.
- RESET_PC=32'hFFFF_FFF8 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, with instr_pc8 wrapping to 0000_0000 at FFFF_FFF8.
- reset asserted mid-stream with queue full -> next cycle instr_valid=0 and imem_addr=RESET_PC. Sequence restarts exactly as in the first scenario.
